// File: rtl/isqrt_pkg.sv
// Shared definitions for the sequential integer square root: FSM encoding,
// iteration count and the widths that derive from the operand width.
package isqrt_pkg;

  localparam int DEF_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // N = Y+1 is DW+1 bits, zero-extended to an even number of bits; one root bit per pair.
  function automatic int iters(input int dw);
    return (dw + 2) / 2;
  endfunction

  function automatic int root_w(input int dw);
    return iters(dw);
  endfunction

  function automatic int rem_w(input int dw);
    return iters(dw) + 1;
  endfunction

  function automatic int prem_w(input int dw);
    return iters(dw) + 2;
  endfunction

  function automatic int cnt_w(input int dw);
    return $clog2(iters(dw));
  endfunction

  localparam int ITER_N = iters(DEF_DW);
  localparam int ROOT_W = root_w(DEF_DW);
  localparam int REM_W  = rem_w(DEF_DW);
  localparam int PREM_W = prem_w(DEF_DW);
  localparam int CNT_W  = cnt_w(DEF_DW);

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root iteration: bring down the next operand pair and
// try to subtract 4*root+1 from the widened partial remainder.
module isqrt_step
  import isqrt_pkg::*;
#(
  parameter int RW = ROOT_W,
  parameter int PW = PREM_W
) (
  input  logic [PW-1:0] rem_in,
  input  logic [RW-1:0] root_in,
  input  logic [1:0]    pair,
  output logic [PW-1:0] rem_out,
  output logic [RW-1:0] root_out
);

  logic [PW+1:0] shifted;
  logic [PW+1:0] trial;
  logic          fits;

  assign shifted = {rem_in, pair};
  assign trial   = (PW+2)'({root_in, 2'b01});
  assign fits    = (shifted >= trial);

  // The remainder never exceeds 2*root, so the truncated top bits are always zero.
  assign rem_out  = fits ? PW'(shifted - trial) : PW'(shifted);
  assign root_out = RW'({root_in, fits});

endmodule

// File: rtl/isqrt_seq.sv
// Sequential floor(sqrt(Y+1)) with remainder, two operand bits per clock,
// fixed latency regardless of operand value.
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DW-1:0]         Y,
  output logic                  busy,
  output logic                  done,
  output logic [root_w(DW)-1:0] root,
  output logic [rem_w(DW)-1:0]  rem,
  output logic                  exact
);

  localparam int IT  = iters(DW);
  localparam int RW  = root_w(DW);
  localparam int QW  = rem_w(DW);
  localparam int PW  = prem_w(DW);
  localparam int CW  = cnt_w(DW);
  localparam int OPW = 2 * IT;

  state_t         state_q;
  state_t         state_d;
  logic           load;
  logic           step_en;
  logic           last_iter;
  logic [DW:0]    n_val;
  logic [OPW-1:0] op_q;
  logic [PW-1:0]  prem_q;
  logic [RW-1:0]  proot_q;
  logic [CW-1:0]  cnt_q;
  logic [PW-1:0]  rem_nx;
  logic [RW-1:0]  root_nx;

  // Y = 2^DW-1 must give N = 2^DW, so the increment is done one bit wider.
  assign n_val     = {1'b0, Y} + {{DW{1'b0}}, 1'b1};
  assign last_iter = (cnt_q == CW'(IT - 1));

  isqrt_step #(
    .RW(RW),
    .PW(PW)
  ) u_step (
    .rem_in  (prem_q),
    .root_in (proot_q),
    .pair    (op_q[OPW-1 -: 2]),
    .rem_out (rem_nx),
    .root_out(root_nx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    step_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        busy    = 1'b1;
        step_en = 1'b1;
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Results only move on the final iteration, so they stay stable through CALC.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      prem_q  <= '0;
      proot_q <= '0;
      cnt_q   <= '0;
      root    <= '0;
      rem     <= '0;
      exact   <= 1'b0;
    end else if (load) begin
      op_q    <= OPW'(n_val);
      prem_q  <= '0;
      proot_q <= '0;
      cnt_q   <= '0;
    end else if (step_en) begin
      op_q    <= {op_q[OPW-3:0], 2'b00};
      prem_q  <= rem_nx;
      proot_q <= root_nx;
      cnt_q   <= last_iter ? '0 : cnt_q + CW'(1);
      if (last_iter) begin
        root  <= root_nx;
        rem   <= QW'(rem_nx);
        exact <= (rem_nx == '0);
      end
    end
  end

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq: directed vectors, start/reset corner
// sequences and random operands against an arithmetic square-root model.
module tb_isqrt_seq;
  import isqrt_pkg::*;

  logic              clk;
  logic              reset;
  logic              start;
  logic [15:0]       Y;
  logic              busy;
  logic              done;
  logic [ROOT_W-1:0] root;
  logic [REM_W-1:0]  rem;
  logic              exact;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int y;
    int root;
    int rem;
    int exact;
  } vec_t;

  vec_t vecs[10];

  isqrt_seq #(.DW(16)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .Y    (Y),
    .busy (busy),
    .done (done),
    .root (root),
    .rem  (rem),
    .exact(exact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Largest r with r*r <= n, found by bisection on plain integers.
  task automatic refSqrt(input int n, output int r, output int m);
    int lo = 0;
    int hi = 257;
    while (hi - lo > 1) begin
      int mid = (lo + hi) / 2;
      if (mid * mid <= n) lo = mid;
      else hi = mid;
    end
    r = lo;
    m = n - lo * lo;
  endtask

  // Latency counts the capture edge as clock 1 and the edge that raises done as clock 10.
  task automatic applyStimulus(input int y, output int r_o, output int m_o, output int e_o,
                               output int lat, output int hold_bad);
    int r0, m0, e0;
    start = 1'b1;
    Y     = 16'(y);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_capture", int'(busy), 1);
    r0 = int'(root); m0 = int'(rem); e0 = int'(exact);
    hold_bad = 0;
    lat = 1;
    Y = 16'($urandom);
    while (!done && lat < 40) begin
      if (int'(root) != r0 || int'(rem) != m0 || int'(exact) != e0 || !busy) hold_bad = 1;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
    checkOutput("busy_in_done", int'(busy), 0);
    r_o = int'(root); m_o = int'(rem); e_o = int'(exact);
    @(posedge clk); #1;
    checkOutput("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    int r, m, e, lat, hb;
    int er, em;
    int prev_done, n_done, saw_done, y;

    vecs[0] = '{0,     1,   0,   1};
    vecs[1] = '{99,    10,  0,   1};
    vecs[2] = '{100,   10,  1,   0};
    vecs[3] = '{16383, 128, 0,   1};
    vecs[4] = '{65535, 256, 0,   1};
    vecs[5] = '{65534, 255, 510, 0};
    vecs[6] = '{8,     3,   0,   1};
    vecs[7] = '{2,     1,   2,   0};
    vecs[8] = '{35,    6,   0,   1};
    vecs[9] = '{47,    6,   12,  0};

    // Reset with start held high must win and clear everything.
    reset = 1'b1; start = 1'b1; Y = 16'd5;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy",  int'(busy),  0);
    checkOutput("reset_done",  int'(done),  0);
    checkOutput("reset_root",  int'(root),  0);
    checkOutput("reset_rem",   int'(rem),   0);
    checkOutput("reset_exact", int'(exact), 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].y, r, m, e, lat, hb);
      checkOutput($sformatf("vec%0d_root", i),    r,   vecs[i].root);
      checkOutput($sformatf("vec%0d_rem", i),     m,   vecs[i].rem);
      checkOutput($sformatf("vec%0d_exact", i),   e,   vecs[i].exact);
      checkOutput($sformatf("vec%0d_latency", i), lat, ITER_N + 1);
      checkOutput($sformatf("vec%0d_hold", i),    hb,  0);
    end

    // start held high with Y=3: one capture per IDLE visit, done every 11 clocks.
    start = 1'b1; Y = 16'd3;
    prev_done = -1; n_done = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (done) begin
        checkOutput("cont_root",  int'(root),  2);
        checkOutput("cont_rem",   int'(rem),   0);
        checkOutput("cont_exact", int'(exact), 1);
        if (prev_done >= 0) checkOutput("cont_period", c - prev_done, 11);
        prev_done = c;
        n_done++;
      end
      Y = busy ? 16'($urandom) : 16'd3;
    end
    checkOutput("cont_done_count", n_done, 5);
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (!busy && !done) break;
    end
    checkOutput("drain_idle", int'(!busy && !done), 1);

    // Reset in the 5th CALC cycle aborts the operation without a done.
    start = 1'b1; Y = 16'd1000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("abort_busy_before", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_busy",  int'(busy),  0);
    checkOutput("abort_done",  int'(done),  0);
    checkOutput("abort_root",  int'(root),  0);
    checkOutput("abort_rem",   int'(rem),   0);
    checkOutput("abort_exact", int'(exact), 0);
    saw_done = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1;
    end
    checkOutput("abort_no_done", saw_done, 0);
    applyStimulus(8, r, m, e, lat, hb);
    checkOutput("after_abort_root",  r, 3);
    checkOutput("after_abort_rem",   m, 0);
    checkOutput("after_abort_exact", e, 1);

    // Random operands against the model and the defining identities.
    for (int k = 0; k < 300; k++) begin
      y = int'($urandom_range(65535, 0));
      applyStimulus(y, r, m, e, lat, hb);
      refSqrt(y + 1, er, em);
      checkOutput($sformatf("rand_root y=%0d", y),     r,   er);
      checkOutput($sformatf("rand_rem y=%0d", y),      m,   em);
      checkOutput($sformatf("rand_exact y=%0d", y),    e,   int'(em == 0));
      checkOutput($sformatf("rand_identity y=%0d", y), r * r + m, y + 1);
      checkOutput($sformatf("rand_rembound y=%0d", y), int'(m <= 2 * r), 1);
      checkOutput($sformatf("rand_latency y=%0d", y),  lat, ITER_N + 1);
      checkOutput($sformatf("rand_hold y=%0d", y),     hb, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
